// File: rtl/tmvp_job_arbiter.sv
// Round-robin job arbiter for two requesters sharing one TMVP core; forwards the
// core result stream with a one-cycle latency. Optional RUN watchdog: TMVP_ARB_WATCHDOG_EN.
module tmvp_job_arbiter #(
    parameter int N              = 32,
    parameter int DATA_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0,
    input  logic                         req1,
    output logic                         gnt0,
    output logic                         gnt1,
    input  logic                         core_ready,
    output logic                         core_start,
    input  logic signed [DATA_WIDTH-1:0] core_tdata,
    input  logic                         core_tvalid,
    output logic signed [DATA_WIDTH-1:0] m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tid,
    output logic                         m_tlast,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic          last_winner;
    logic          beat;
    logic          last_beat;
    logic          win1;
    logic          wd_fire;

    assign beat      = (state == RUN) && core_tvalid;
    assign last_beat = beat && (beat_cnt == CW'(N - 1));
    // Requester 1 wins when alone, or when both ask and requester 0 won last time.
    assign win1      = req1 && (!req0 || last_winner == 1'b0);

`ifdef TMVP_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WW-1:0] wd_cnt;
    assign wd_fire = (state == RUN) && !core_tvalid && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_fire     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // NOTE: async reset clears every register so outputs drop in the same cycle reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_winner <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tid       <= 1'b0;
            m_tlast     <= 1'b0;
`ifdef TMVP_ARB_WATCHDOG_EN
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values.
            core_start <= 1'b0;
            m_tvalid   <= beat;
            m_tdata    <= beat ? core_tdata : '0;
            m_tid      <= beat && gnt1;
            m_tlast    <= last_beat;
`ifdef TMVP_ARB_WATCHDOG_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if ((req0 || req1) && core_ready) begin
                        state      <= START;
                        gnt0       <= !win1;
                        gnt1       <= win1;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                START: begin
                    state <= RUN;
`ifdef TMVP_ARB_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                RUN: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
`ifdef TMVP_ARB_WATCHDOG_EN
                    wd_cnt <= beat ? '0 : wd_cnt + 1'b1;
`endif
                    if (last_beat || wd_fire) begin
                        state       <= DONE;
                        gnt0        <= 1'b0;
                        gnt1        <= 1'b0;
                        last_winner <= gnt1;
`ifdef TMVP_ARB_WATCHDOG_EN
                        err_timeout <= wd_fire;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmvp_job_arbiter.sv
// Directed bench for tmvp_job_arbiter: vector table for IDLE-side behaviour,
// hand sequences for full jobs, contention, mid-job reset and the optional watchdog.
module tb_tmvp_job_arbiter;

    localparam int N  = 32;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req0, req1, core_ready, core_tvalid;
    logic signed [DW-1:0] core_tdata;
    logic                 gnt0, gnt1, core_start, m_tvalid, m_tid, m_tlast, busy, err_timeout;
    logic signed [DW-1:0] m_tdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tmvp_job_arbiter #(.N(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .core_ready(core_ready), .core_start(core_start), .core_tdata(core_tdata),
        .core_tvalid(core_tvalid), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tid(m_tid),
        .m_tlast(m_tlast), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic       req0, req1, ready, tvalid;
        logic [7:0] data;
        logic       e_gnt0, e_gnt1, e_start, e_busy, e_mvalid;
        logic [7:0] e_mdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
        check({tag, "_m_tdata"}, 32'(m_tdata), 0);
        check({tag, "_m_tid"}, 32'(m_tid), 0);
        check({tag, "_m_tlast"}, 32'(m_tlast), 0);
    endtask

    // Drives N beats (with two idle gaps) from RUN and follows the job through DONE to IDLE.
    task automatic run_beats(input logic id);
        for (int i = 1; i <= N; i++) begin
            if (i == 8 || i == 20) begin
                core_tvalid = 1'b0;
                core_tdata  = 8'sd77;
                step();
                check_idle_outputs("gap");
                check("gap_gnt", 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
            end
            core_tvalid = 1'b1;
            core_tdata  = DW'(i);
            step();
            check("beat_valid", 32'(m_tvalid), 1);
            check("beat_data", 32'(m_tdata), 32'(i));
            check("beat_tid", 32'(m_tid), 32'(id));
            check("beat_last", 32'(m_tlast), 32'(i == N));
            check("beat_err", 32'(err_timeout), 0);
            if (i < N) check("beat_gnt", 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
        end
        check("done_gnt", 32'({gnt1, gnt0}), 0);
        check("done_busy", 32'(busy), 1);
        core_tvalid = 1'b0;
        core_tdata  = 8'sd0;
        step();
        check("idle_busy", 32'(busy), 0);
        check_idle_outputs("after_done");
    endtask

    task automatic grant_phase(input logic r0, input logic r1, input logic id);
        bit got = 0;
        req0 = r0; req1 = r1; core_ready = 1'b1; core_tvalid = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            step();
            got = gnt0 | gnt1;
        end
        check("grant_seen", 32'(got), 1);
        check("grant_idx", 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
        check("start_pulse", 32'(core_start), 1);
        step();
        check("start_once", 32'(core_start), 0);
    endtask

    task automatic do_job(input logic r0, input logic r1, input logic id);
        grant_phase(r0, r1, id);
        run_beats(id);
    endtask

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; core_ready = 0; core_tvalid = 0; core_tdata = 0;
        #12;
        check("rst_gnt", 32'({gnt1, gnt0}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(core_start), 0);
        check("rst_err", 32'(err_timeout), 0);
        check_idle_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Stray beat in IDLE, core busy for 10 cycles, then grant to requester 1.
        vecs.push_back('{0, 0, 1, 1, 8'd5, 0, 0, 0, 0, 0, 8'd0});
        for (int k = 0; k < 10; k++)
            vecs.push_back('{0, 1, 0, (k == 3), 8'd5, 0, 0, 0, 0, 0, 8'd0});
        vecs.push_back('{0, 1, 1, 0, 8'd0, 0, 1, 1, 1, 0, 8'd0});
        vecs.push_back('{0, 0, 0, 1, 8'd9, 0, 1, 0, 1, 0, 8'd0});
        vecs.push_back('{1, 0, 1, 0, 8'd0, 0, 1, 0, 1, 0, 8'd0});
        foreach (vecs[v]) begin
            req0 = vecs[v].req0; req1 = vecs[v].req1; core_ready = vecs[v].ready;
            core_tvalid = vecs[v].tvalid; core_tdata = vecs[v].data;
            step();
            check($sformatf("vec%0d_gnt0", v), 32'(gnt0), 32'(vecs[v].e_gnt0));
            check($sformatf("vec%0d_gnt1", v), 32'(gnt1), 32'(vecs[v].e_gnt1));
            check($sformatf("vec%0d_start", v), 32'(core_start), 32'(vecs[v].e_start));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
            check($sformatf("vec%0d_mvalid", v), 32'(m_tvalid), 32'(vecs[v].e_mvalid));
            check($sformatf("vec%0d_mdata", v), 32'(m_tdata), 32'(vecs[v].e_mdata));
        end
        req0 = 0;
        run_beats(1'b1);

        // Contention with last winner 1: grants alternate 0,1,0.
        do_job(1, 1, 0);
        do_job(1, 1, 1);
        do_job(1, 1, 0);
        // Sole requester 0 wins even though it won last.
        do_job(1, 0, 0);

        // Reset at beat 10 of a requester-1 job.
        grant_phase(0, 1, 1);
        for (int i = 1; i <= 9; i++) begin
            core_tvalid = 1'b1; core_tdata = DW'(i);
            step();
        end
        check("pre_rst_valid", 32'(m_tvalid), 1);
        core_tdata = DW'(10);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'({gnt1, gnt0}), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(core_start), 0);
        check("mid_rst_err", 32'(err_timeout), 0);
        check_idle_outputs("mid_rst");
        step();
        reset = 1'b0; core_tvalid = 1'b0;
        grant_phase(1, 1, 0);
        run_beats(1'b0);

`ifdef TMVP_ARB_WATCHDOG_EN
        // Three beats then silence: abort 16 cycles after the last beat.
        grant_phase(0, 1, 1);
        for (int i = 1; i <= 3; i++) begin
            core_tvalid = 1'b1; core_tdata = DW'(i);
            step();
        end
        core_tvalid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("wd_quiet_err", 32'(err_timeout), 0);
            check("wd_quiet_gnt", 32'(gnt1), 1);
        end
        step();
        check("wd_err", 32'(err_timeout), 1);
        check("wd_gnt", 32'({gnt1, gnt0}), 0);
        check("wd_no_last", 32'(m_tlast), 0);
        check("wd_busy", 32'(busy), 1);
        step();
        check("wd_err_pulse", 32'(err_timeout), 0);
        check("wd_idle", 32'(busy), 0);
        // Pointer moved to requester 1, so contention now goes to requester 0.
        do_job(1, 1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tmvp_job_arbiter.md
TMVP_JOB_ARBITER -- requirements
Module: tmvp_job_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, the polynomial length; the core returns N result beats per job.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 4, the signed coefficient width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit in cycles.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have ports req0 and req1, input, 1 each, job requests from requesters 0 and 1.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 each, the registered one-hot grant held for the whole job.
REQ-008 The block SHALL have port core_ready, input, 1, the core-idle indication.
REQ-009 The block SHALL have port core_start, output, 1, a one-cycle start pulse to the core.
REQ-010 The block SHALL have ports core_tdata (input, DATA_WIDTH, signed) and core_tvalid (input, 1), the core result stream.
REQ-011 The block SHALL have ports m_tdata (output, DATA_WIDTH, signed) and m_tvalid (output, 1), the forwarded result stream.
REQ-012 The block SHALL have port m_tid, output, 1, the index of the granted requester for the current beat.
REQ-013 The block SHALL have port m_tlast, output, 1, marking beat N of a job.
REQ-014 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 The block SHALL have port err_timeout, output, 1, a one-cycle watchdog abort pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, START, RUN and DONE.
REQ-017 IDLE SHALL go to START when (req0|req1) is high and core_ready is high, latching the grant on that edge.
REQ-018 Arbitration SHALL be round-robin on a 1-bit last-winner pointer: a sole requester wins; if both request, the one that is not the last winner wins.
REQ-019 The pointer SHALL update only on entry to DONE.
REQ-020 START SHALL assert core_start for exactly one cycle and then go to RUN unconditionally.
REQ-021 RUN SHALL count core_tvalid beats with a counter of width clog2(N)+1 that is cleared on entry to START.
REQ-022 Each counted beat SHALL appear one cycle later on m_tdata/m_tvalid with m_tid equal to the grant index, giving a latency of 1 and no modification of the data.
REQ-023 m_tlast SHALL be high together with m_tvalid on beat N, and RUN SHALL then go to DONE.
REQ-024 DONE SHALL last one cycle, deassert the grant, and return to IDLE; the earliest next grant is on the following cycle.
REQ-025 Changes on req0/req1 after the grant SHALL be ignored until IDLE; a requester dropping its request does not abort the job.
REQ-026 core_tvalid outside RUN SHALL be ignored, with no output and no count.
REQ-027 When m_tvalid is low, m_tdata, m_tid and m_tlast SHALL be 0.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously.

Reset
REQ-029 On reset all outputs SHALL be 0, the state SHALL be IDLE, the beat and watchdog counters SHALL be 0, and the pointer SHALL be 1 so that req0 wins first.
REQ-030 A reset asserted mid-job SHALL abort the job immediately with no m_tlast and no err_timeout, and SHALL drop the grant asynchronously.

Configuration
REQ-031 The macro TMVP_ARB_WATCHDOG_EN SHALL control the RUN-state watchdog.
REQ-032 With TMVP_ARB_WATCHDOG_EN defined, the watchdog counter SHALL clear on each counted beat and on entry to RUN.
REQ-033 With TMVP_ARB_WATCHDOG_EN defined, the watchdog SHALL fire when the counter reaches TIMEOUT_CYCLES-1 with no beat that cycle: err_timeout pulses for 1 cycle, the FSM goes to DONE (pointer updates), and m_tlast is not asserted.
REQ-034 With TMVP_ARB_WATCHDOG_EN undefined, there SHALL be no watchdog counter, err_timeout SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-035 The bench SHALL cover a single job: req0=1, core_ready=1, 32 beats of 1..32 -> gnt0 high, one core_start pulse, m_tdata 1..32 each one cycle late, m_tid=0, m_tlast on value 32.
REQ-036 The bench SHALL cover contention: req0=req1=1 held for three jobs -> grants 0,1,0, each job of 32 beats with the matching m_tid.
REQ-037 The bench SHALL cover core busy: req1=1 with core_ready=0 for 10 cycles -> no grant and no core_start until core_ready rises, then gnt1 on the next edge.
REQ-038 The bench SHALL cover a stray beat: core_tvalid pulse in IDLE with data 5 -> m_tvalid stays 0.
REQ-039 The bench SHALL cover the watchdog with TMVP_ARB_WATCHDOG_EN defined and TIMEOUT_CYCLES=16: 3 beats then silence -> err_timeout pulse 16 cycles after the last beat, grant released, no m_tlast.
REQ-040 The bench SHALL cover reset mid-job: reset asserted at beat 10 -> all outputs 0 in the same cycle, and after release req0 wins again.
